tdm_demux_1x8: RTL and testbench

//  Receive-side partner of the 8:1 serial-select mux tree. Takes a time-division serial bit

---
 rtl/tdm_demux_1x8.sv | 146 ++++++++++++++
 tb/tb_tdm_demux_1x8.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1x8.sv
// tdm_demux_1x8 -- serial TDM stream to parallel frame demultiplexer.
//
// This is the receive-side partner of the 8:1 serial-select mux tree. It
// rebuilds each frame from a serial stream that carries one lane bit per slot,
// with slot 0 first. A frame-sync strobe marks slot 0. Each completed frame is
// presented on a valid/ready output register, and backpressure is applied
// toward the serial source.
//
// Optional feature: define TDM_DEMUX_PARITY_EN to add a trailing even-parity
// slot (slot LANES) to every frame. A frame that fails the parity check is
// dropped and par_err_out pulses instead of publishing it.
//
// Ports:
//   clk_in        rising-edge clock
//   rst_n_in      asynchronous active-low reset
//   d_in          serial data bit for the current slot
//   valid_in      d_in qualifier; a bit is accepted on valid_in & ready_out
//   sync_in       with valid_in, marks d_in as slot 0
//   ready_out     source may present a bit (combinational)
//   y_out         rebuilt frame, y_out[i] = bit received in slot i
//   y_valid_out   y_out holds an unconsumed frame
//   y_ready_in    sink accepts y_out on y_valid_out & y_ready_in
//   slot_out      index of the next slot to be written
//   sync_err_out  sticky: sync_in seen mid-frame
//   err_clr_in    synchronous clear of sync_err_out
//   par_err_out   one-cycle pulse on parity mismatch (0 without the macro)

module tdm_demux_1x8 #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned SLOT_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              d_in,
    input  logic              valid_in,
    input  logic              sync_in,
    output logic              ready_out,
    output logic [LANES-1:0]  y_out,
    output logic              y_valid_out,
    input  logic              y_ready_in,
    output logic [SLOT_W-1:0] slot_out,
    output logic              sync_err_out,
    input  logic              err_clr_in,
    output logic              par_err_out
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned LAST = LANES;
`else
    localparam int unsigned LAST = LANES - 1;
`endif
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LAST);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state;
    logic [LANES-1:0] frame_buf;
    logic [LANES-1:0] frame_next;
    logic             last_slot;
    logic             accept;
    logic             frame_start;

    assign last_slot = (slot_out == LAST_SLOT);

    // Only the final slot is held off: it is the one that would overwrite a
    // full, non-draining output register.
    assign ready_out = !(state == LOCK && last_slot && y_valid_out && !y_ready_in);
    assign accept    = valid_in & ready_out;

    // Sync starts a fresh frame when hunting or when it arrives mid-frame
    // (realign). Sync on slot 0 in LOCK is just a normal frame start.
    assign frame_start = sync_in && (state == HUNT || slot_out != '0);

    // Partial frame with the current bit merged into its slot. The parity
    // slot matches no lane, so it leaves the buffer untouched.
    always_comb begin
        frame_next = frame_buf;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (slot_out == SLOT_W'(i)) begin
                frame_next[i] = d_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= HUNT;
            slot_out     <= '0;
            frame_buf    <= '0;
            y_out        <= '0;
            y_valid_out  <= 1'b0;
            sync_err_out <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_out  <= 1'b0;
`endif
        end else begin
`ifdef TDM_DEMUX_PARITY_EN
            par_err_out <= 1'b0;
`endif
            // Defaults first; a publish or new sync error below overrides them.
            if (y_valid_out && y_ready_in) begin
                y_valid_out <= 1'b0;
            end
            if (err_clr_in) begin
                sync_err_out <= 1'b0;
            end

            if (accept) begin
                if (frame_start) begin
                    frame_buf <= {{(LANES-1){1'b0}}, d_in};
                    slot_out  <= SLOT_W'(1);
                    state     <= LOCK;
                    if (state == LOCK) begin
                        sync_err_out <= 1'b1;
                    end
                end else if (state == LOCK) begin
                    frame_buf <= frame_next;
                    if (last_slot) begin
                        slot_out <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                        if (^{frame_buf, d_in}) begin
                            par_err_out <= 1'b1;
                        end else begin
                            y_out       <= frame_next;
                            y_valid_out <= 1'b1;
                        end
`else
                        y_out       <= frame_next;
                        y_valid_out <= 1'b1;
`endif
                    end else begin
                        slot_out <= slot_out + SLOT_W'(1);
                    end
                end
            end
        end
    end

`ifndef TDM_DEMUX_PARITY_EN
    assign par_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1x8.sv
module tb_tdm_demux_1x8;

    localparam int LANES = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int LAST = LANES;
`else
    localparam int LAST = LANES - 1;
`endif
    localparam int FS = LAST + 1;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             d_in;
    logic             valid_in;
    logic             sync_in;
    logic             ready_out;
    logic [LANES-1:0] y_out;
    logic             y_valid_out;
    logic             y_ready_in;
    logic [3:0]       slot_out;
    logic             sync_err_out;
    logic             err_clr_in;
    logic             par_err_out;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    logic [7:0] exp_q[$];
    int         hs_q[$];

    tdm_demux_1x8 #(.LANES(8), .SLOT_W(4)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .d_in        (d_in),
        .valid_in    (valid_in),
        .sync_in     (sync_in),
        .ready_out   (ready_out),
        .y_out       (y_out),
        .y_valid_out (y_valid_out),
        .y_ready_in  (y_ready_in),
        .slot_out    (slot_out),
        .sync_err_out(sync_err_out),
        .err_clr_in  (err_clr_in),
        .par_err_out (par_err_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every handshake consumes the oldest expected frame.
    always @(negedge clk_in) begin
        if (rst_n_in === 1'b1 && y_valid_out === 1'b1 && y_ready_in === 1'b1) begin
            hs_q.push_back(cyc_cnt);
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", {24'h0, y_out}, 32'hFFFF_FFFF);
            end else begin
                chk("frame_data", {24'h0, y_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic slot_bit(input logic [7:0] f, input int i);
        return (i < LANES) ? f[i] : ^f;
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_bit(input logic d, input logic s, output int waited);
        valid_in = 1'b1;
        d_in     = d;
        sync_in  = s;
        waited   = 0;
        #1;
        while (!ready_out && waited < 20) begin
            cyc();
            waited++;
        end
        if (!ready_out) chk("ready_timeout", {31'h0, ready_out}, 32'h1);
        cyc();
        valid_in = 1'b0;
        sync_in  = 1'b0;
    endtask

    task automatic send_slots(input logic [7:0] f, input int lo, input int hi, output int waited);
        int w;
        waited = 0;
        for (int i = lo; i <= hi; i++) begin
            send_bit(slot_bit(f, i), 1'b0, w);
            waited += w;
        end
    endtask

    task automatic send_frame(input logic [7:0] f, input logic s, output int waited);
        int w0, w1;
        send_bit(f[0], s, w0);
        send_slots(f, 1, LAST, w1);
        exp_q.push_back(f);
        waited = w0 + w1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, tw;
        rst_n_in = 1'b0; d_in = 1'b0; valid_in = 1'b0; sync_in = 1'b0;
        y_ready_in = 1'b1; err_clr_in = 1'b0;
        repeat (3) cyc();
        chk("rst_slot", slot_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_valid", y_valid_out, 0);
        chk("rst_serr", sync_err_out, 0);
        chk("rst_perr", par_err_out, 0);
        chk("rst_ready", ready_out, 1);
        rst_n_in = 1'b1;
        cyc();

        // 1: single frame, immediate drain
        send_frame(8'h4D, 1'b1, w);
        chk("t1_valid", y_valid_out, 1);
        chk("t1_y", y_out, 8'h4D);
        chk("t1_slot", slot_out, 0);
        chk("t1_perr", par_err_out, 0);
        cyc();
        chk("t1_valid_drop", y_valid_out, 0);

        // 2: back-to-back frames, sync on the first only
        hs_q.delete();
        send_frame(8'h4D, 1'b0, w);
        tw = w;
        send_frame(8'hA5, 1'b0, w);
        tw += w;
        chk("t2_y", y_out, 8'hA5);
        cyc();
        chk("t2_no_stall", tw, 0);
        chk("t2_hs_count", hs_q.size(), 2);
        if (hs_q.size() == 2) chk("t2_hs_gap", hs_q[1] - hs_q[0], FS);
        chk("t2_serr", sync_err_out, 0);

        // 3: backpressure on the final slot
        y_ready_in = 1'b0;
        send_frame(8'h4D, 1'b0, w);
        send_slots(8'h3C, 0, LAST - 1, w);
        chk("t3_pre_stall", w, 0);
        valid_in = 1'b1; d_in = slot_bit(8'h3C, LAST); sync_in = 1'b0;
        #1;
        chk("t3_ready_low", ready_out, 0);
        cyc();
        chk("t3_y_hold", y_out, 8'h4D);
        chk("t3_valid_hold", y_valid_out, 1);
        chk("t3_slot_hold", slot_out, LAST);
        y_ready_in = 1'b1;
        #1;
        chk("t3_ready_high", ready_out, 1);
        exp_q.push_back(8'h3C);
        cyc();
        valid_in = 1'b0;
        chk("t3_y_next", y_out, 8'h3C);
        chk("t3_valid_next", y_valid_out, 1);
        chk("t3_slot_wrap", slot_out, 0);
        cyc();
        chk("t3_valid_drop", y_valid_out, 0);

        // 4: mid-frame sync, realign, sticky error and clear
        send_slots(8'h0F, 0, 3, w);
        chk("t4_slot4", slot_out, 4);
        sync_in = 1'b1; d_in = 1'b1;
        cyc();
        sync_in = 1'b0;
        chk("t4_idle_slot", slot_out, 4);
        chk("t4_idle_serr", sync_err_out, 0);
        send_bit(1'b1, 1'b1, w);
        chk("t4_serr_set", sync_err_out, 1);
        chk("t4_realign_slot", slot_out, 1);
        send_slots(8'hA5, 1, LAST, w);
        exp_q.push_back(8'hA5);
        chk("t4_y", y_out, 8'hA5);
        chk("t4_serr_sticky", sync_err_out, 1);
        err_clr_in = 1'b1;
        cyc();
        err_clr_in = 1'b0;
        chk("t4_serr_clr", sync_err_out, 0);
        send_slots(8'h4D, 0, 1, w);
        err_clr_in = 1'b1;
        send_bit(1'b0, 1'b1, w);
        err_clr_in = 1'b0;
        chk("t4_err_wins", sync_err_out, 1);
        chk("t4_realign2", slot_out, 1);
        send_slots(8'h3C, 1, LAST, w);
        exp_q.push_back(8'h3C);
        chk("t4_y2", y_out, 8'h3C);
        err_clr_in = 1'b1;
        cyc();
        err_clr_in = 1'b0;
        chk("t4_serr_clr2", sync_err_out, 0);

        // 5: reset mid-frame with a held frame, then hunt for sync
        y_ready_in = 1'b0;
        send_frame(8'h4D, 1'b0, w);
        send_slots(8'h3C, 0, 3, w);
        chk("t5_slot4", slot_out, 4);
        chk("t5_held", y_valid_out, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("t5_rst_valid", y_valid_out, 0);
        chk("t5_rst_y", y_out, 0);
        chk("t5_rst_slot", slot_out, 0);
        exp_q.delete();
        cyc();
        rst_n_in = 1'b1;
        y_ready_in = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(i[0], 1'b0, w);
        chk("t5_hunt_slot", slot_out, 0);
        chk("t5_hunt_valid", y_valid_out, 0);
        send_frame(8'hA5, 1'b1, w);
        chk("t5_relock_y", y_out, 8'hA5);
        chk("t5_relock_valid", y_valid_out, 1);
        cyc();

`ifdef TDM_DEMUX_PARITY_EN
        // 6: parity good then bad
        send_frame(8'h4D, 1'b1, w);
        chk("t6_good_valid", y_valid_out, 1);
        chk("t6_good_perr", par_err_out, 0);
        cyc();
        send_slots(8'h4D, 0, LANES - 1, w);
        send_bit(1'b1, 1'b0, w);
        chk("t6_bad_perr", par_err_out, 1);
        chk("t6_bad_valid", y_valid_out, 0);
        cyc();
        chk("t6_perr_pulse", par_err_out, 0);
        chk("t6_still_invalid", y_valid_out, 0);
`endif

        cyc();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
